// File: rtl/mod_counter.sv
// Modulus up/down counter: clear > load > count > hold priority, wrap or saturate at the bound.
// Define MOD_COUNTER_STICKY_EN to add the sticky overflow flag output ovf.
module mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             up,
  input  logic [WIDTH-1:0] modulus,
  input  logic             wrap,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             rollover
`ifdef MOD_COUNTER_STICKY_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic [WIDTH-1:0] max_val;
  logic             at_max, at_zero, above_max;
  logic             bound_hit;

  // Modulus 0 selects the full range; all compares stay WIDTH bits so 2^WIDTH-1 wraps cleanly.
  assign max_val   = (modulus == '0) ? '1 : (modulus - ONE);
  assign at_max    = (count_q == max_val);
  assign at_zero   = (count_q == '0);
  assign above_max = (count_q > max_val);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d   = count_q;
    roll_d    = 1'b0;
    bound_hit = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (D > max_val) ? max_val : D;
    end else if (en) begin
      if (above_max) begin
        bound_hit = 1'b1;
        if (up && wrap) begin
          count_d = '0;
          roll_d  = 1'b1;
        end else begin
          count_d = max_val;
        end
      end else if (up) begin
        if (at_max) begin
          bound_hit = 1'b1;
          if (wrap) begin
            count_d = '0;
            roll_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (at_zero) begin
          bound_hit = 1'b1;
          if (wrap) begin
            count_d = max_val;
            roll_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
      roll_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
    end
  end

`ifdef MOD_COUNTER_STICKY_EN
  logic ovf_q, ovf_d;

  // Sticky: set by any enabled count attempt at a bound, cleared only by clear; load leaves it alone.
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (bound_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_bound;
  assign unused_bound = bound_hit;
`endif

  assign Q        = count_q;
  assign rollover = roll_q;
  assign tc       = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4): directed scenarios plus random stimulus
// compared against an integer-arithmetic reference model.
module tb_mod_counter;

  localparam int W = 4;
  localparam int FULL = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset_L;
  logic         en, clear, load, up, wrap;
  logic [W-1:0] D, modulus;
  logic [W-1:0] Q;
  logic         tc, rollover;
`ifdef MOD_COUNTER_STICKY_EN
  logic         ovf;
`endif

  mod_counter #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .en       (en),
    .clear    (clear),
    .load     (load),
    .D        (D),
    .up       (up),
    .modulus  (modulus),
    .wrap     (wrap),
    .Q        (Q),
    .tc       (tc),
    .rollover (rollover)
`ifdef MOD_COUNTER_STICKY_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_q    = 0;
  int m_roll = 0;
  int m_ovf  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int range_max(input int m);
    return (m == 0) ? FULL : m - 1;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_q = 0; m_roll = 0; m_ovf = 0;
  endtask

  // Called at posedge+1: drive, check combinational tc, clock, update model, check registers.
  task automatic cycle(input string tag, input bit e, input bit c, input bit l, input int d,
                       input bit u, input int m, input bit w);
    int mx, nq, nr;
    bit bnd;
    en = e; clear = c; load = l; D = W'(d); up = u; modulus = W'(m); wrap = w;
    mx = range_max(m);
    #1;
    check({tag, "_tc"}, {31'd0, tc}, (e && ((u && m_q == mx) || (!u && m_q == 0))) ? 1 : 0);
    @(posedge clock);
    #1;
    nq = m_q; nr = 0; bnd = 0;
    if (c) nq = 0;
    else if (l) nq = min2(d, mx);
    else if (e) begin
      if (m_q > mx) begin
        bnd = 1;
        if (u && w) begin nq = 0; nr = 1; end
        else nq = mx;
      end else if (u) begin
        bnd = (m_q == mx);
        if (w) begin nq = (m_q + 1) % (mx + 1); nr = bnd; end
        else nq = min2(m_q + 1, mx);
      end else begin
        bnd = (m_q == 0);
        if (w) begin nq = (m_q + mx) % (mx + 1); nr = bnd; end
        else nq = (m_q == 0) ? 0 : m_q - 1;
      end
    end
    m_q = nq; m_roll = nr;
    if (c) m_ovf = 0;
    else if (bnd) m_ovf = 1;
    check({tag, "_q"}, {28'd0, Q}, m_q);
    check({tag, "_roll"}, {31'd0, rollover}, m_roll);
`ifdef MOD_COUNTER_STICKY_EN
    check({tag, "_ovf"}, {31'd0, ovf}, m_ovf);
`endif
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #2;
    model_reset();
    check("rst_q", {28'd0, Q}, 0);
    check("rst_roll", {31'd0, rollover}, 0);
    @(posedge clock);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L = 1'b0; en = 0; clear = 0; load = 0; D = '0; up = 1; modulus = '0; wrap = 1;
    @(posedge clock);
    #1;
    do_reset();

    // Mod-10 wrapping up-count from reset
    for (int i = 0; i < 12; i++) begin
      cycle("mod10", 1, 0, 0, 0, 1, 10, 1);
      if (i == 8) check("mod10_at9", {28'd0, Q}, 9);
      if (i == 9) check("mod10_wrap_pulse", {31'd0, rollover}, 1);
    end
    check("mod10_end", {28'd0, Q}, 2);

    // Saturating down-count in full range
    cycle("sat_ld", 0, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("sat_dn", 1, 0, 0, 0, 0, 0, 0);
    check("sat_floor", {28'd0, Q}, 0);

    // Load clamp, then clear beats load
    cycle("clamp", 0, 0, 1, 12, 1, 6, 1);
    check("clamp_val", {28'd0, Q}, 5);
    cycle("clr_wins", 1, 1, 1, 12, 1, 6, 1);
    check("clr_wins_val", {28'd0, Q}, 0);

    // Modulus lowered below the count
    cycle("mdrop_ld", 0, 0, 1, 9, 1, 0, 1);
    cycle("mdrop_dn1", 1, 0, 0, 0, 0, 5, 1);
    check("mdrop_dn1_val", {28'd0, Q}, 4);
    cycle("mdrop_dn2", 1, 0, 0, 0, 0, 5, 1);
    check("mdrop_dn2_val", {28'd0, Q}, 3);
    cycle("mdrop_ld2", 0, 0, 1, 9, 1, 0, 1);
    cycle("mdrop_up", 1, 0, 0, 0, 1, 5, 1);
    check("mdrop_up_roll", {31'd0, rollover}, 1);

    // Async reset mid-count
    cycle("ar_clr", 0, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) cycle("ar_cnt", 1, 0, 0, 0, 1, 0, 1);
    check("ar_at7", {28'd0, Q}, 7);
    #3;
    reset_L = 1'b0;
    #1;
    model_reset();
    check("ar_q_now", {28'd0, Q}, 0);
    check("ar_roll_now", {31'd0, rollover}, 0);
    #1;
    reset_L = 1'b1;
    @(posedge clock);
    #1;
    // The edge above saw reset_L high with en=1, up=1: count advances to 1
    m_q = 1;
    check("ar_resume1", {28'd0, Q}, 1);
    cycle("ar_resume", 1, 0, 0, 0, 1, 0, 1);
    check("ar_resume2", {28'd0, Q}, 2);

    // Full-range wrap at 2^W-1, then idle
    cycle("full_ld", 0, 0, 1, 15, 1, 0, 1);
    cycle("full_wrap", 1, 0, 0, 0, 1, 0, 1);
    check("full_wrap_q", {28'd0, Q}, 0);
    check("full_wrap_roll", {31'd0, rollover}, 1);
    cycle("full_idle", 0, 0, 0, 0, 1, 0, 1);
    check("full_idle_roll", {31'd0, rollover}, 0);
    check("full_idle_tc", {31'd0, tc}, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r, mm;
      r  = $urandom_range(0, 99);
      mm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : ((i / 50) % 2 ? 0 : 7);
      cycle("rnd", $urandom_range(0, 9) != 0, r < 3, (r >= 3) && (r < 10),
            $urandom_range(0, 15), $urandom_range(0, 1), mm, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
